// File: rtl/i2c_slave_rx.sv
// I2C target (slave) byte engine: address match, write receive, read transmit.
// SCL and SDA are synchronised into sys_clk; SDA is open-drain (0 or released).
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WR_DATA   = 3'd3,
    S_WR_ACK    = 3'd4,
    S_RD_DATA   = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_cnt_nxt;
  logic [6:0]  r_shift, w_shift_nxt;
  logic [6:0]  r_tx_shift, w_tx_shift_nxt;
  logic        r_rw, w_rw_nxt;
  logic        r_oe, w_oe_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_rx_valid, w_rx_valid_nxt;
  logic        r_tx_req, w_tx_req_nxt;
  logic        r_addr_match, w_addr_match_nxt;
  logic        r_busy, w_busy_nxt;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL held high across both samples so a data change near an SCL edge is not mistaken for a condition
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign sda        = r_oe ? 1'b0 : 1'bz;
  assign tx_req     = r_tx_req;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign addr_match = r_addr_match;
  assign busy       = r_busy;

  // Synchroniser chains plus one history flop per line for edge/condition detection
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl_in;
      r_sda_sync[0] <= sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; bus conditions override any SCL edge in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_IDLE:      w_state_nxt = S_IDLE;
        S_ADDR: begin
          if (w_scl_rise && r_bit_cnt == 4'd7)
            w_state_nxt = (r_shift == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
          else
            w_state_nxt = S_ADDR;
        end
        S_ADDR_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd9) w_state_nxt = r_rw ? S_RD_DATA : S_WR_DATA;
          else                                 w_state_nxt = S_ADDR_ACK;
        end
        S_WR_DATA: begin
          if (w_scl_rise && r_bit_cnt == 4'd7) w_state_nxt = S_WR_ACK;
          else                                 w_state_nxt = S_WR_DATA;
        end
        S_WR_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd9) w_state_nxt = S_WR_DATA;
          else                                 w_state_nxt = S_WR_ACK;
        end
        S_RD_DATA: begin
          if (w_scl_rise && r_bit_cnt == 4'd7) w_state_nxt = S_RD_ACK;
          else                                 w_state_nxt = S_RD_DATA;
        end
        S_RD_ACK: begin
          if (w_scl_rise && r_bit_cnt == 4'd9 && w_sda)  w_state_nxt = S_WAIT_STOP;
          else if (w_scl_fall && r_bit_cnt == 4'd10)     w_state_nxt = S_RD_DATA;
          else                                           w_state_nxt = S_RD_ACK;
        end
        S_WAIT_STOP: w_state_nxt = S_WAIT_STOP;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath/output next values. Bit counter: 0..7 data bits, 8 = awaiting ACK fall,
  // 9 = ACK slot in progress, 10 = master ACKed a read byte
  always_comb begin
    w_cnt_nxt        = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_tx_shift_nxt   = r_tx_shift;
    w_rw_nxt         = r_rw;
    w_oe_nxt         = r_oe;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_tx_req_nxt     = 1'b0;
    w_addr_match_nxt = r_addr_match;
    w_busy_nxt       = r_busy;
    if (w_stop) begin
      w_cnt_nxt        = 4'd0;
      w_oe_nxt         = 1'b0;
      w_addr_match_nxt = 1'b0;
      w_busy_nxt       = 1'b0;
    end else if (w_start) begin
      w_cnt_nxt        = 4'd0;
      w_shift_nxt      = 7'd0;
      w_oe_nxt         = 1'b0;
      w_addr_match_nxt = 1'b0;
      w_busy_nxt       = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[5:0], w_sda};
            w_cnt_nxt   = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) w_rw_nxt = w_sda;
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_nxt         = 1'b1;
            w_addr_match_nxt = 1'b1;
            w_cnt_nxt        = 4'd9;
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_cnt_nxt = 4'd0;
            if (r_rw) begin
              w_tx_shift_nxt = tx_data[6:0];
              w_oe_nxt       = ~tx_data[7];
              w_tx_req_nxt   = 1'b1;
            end else begin
              w_oe_nxt = 1'b0;
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[5:0], w_sda};
            w_cnt_nxt   = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_rx_data_nxt  = {r_shift, w_sda};
              w_rx_valid_nxt = 1'b1;
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_nxt  = 1'b1;
            w_cnt_nxt = 4'd9;
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_oe_nxt  = 1'b0;
            w_cnt_nxt = 4'd0;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            w_oe_nxt       = ~r_tx_shift[6];
            w_tx_shift_nxt = {r_tx_shift[5:0], 1'b1};
          end
        end
        S_RD_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_nxt  = 1'b0;
            w_cnt_nxt = 4'd9;
          end else if (w_scl_rise && r_bit_cnt == 4'd9 && !w_sda) begin
            w_cnt_nxt = 4'd10;
          end else if (w_scl_fall && r_bit_cnt == 4'd10) begin
            w_cnt_nxt      = 4'd0;
            w_tx_shift_nxt = tx_data[6:0];
            w_oe_nxt       = ~tx_data[7];
            w_tx_req_nxt   = 1'b1;
          end
        end
        S_IDLE, S_WAIT_STOP: w_oe_nxt = 1'b0;
        default:             w_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= 7'd0;
      r_tx_shift   <= 7'd0;
      r_rw         <= 1'b0;
      r_oe         <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_addr_match <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_bit_cnt    <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_rw         <= w_rw_nxt;
      r_oe         <= w_oe_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_tx_req     <= w_tx_req_nxt;
      r_addr_match <= w_addr_match_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit address this target answers.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on scl_in/sda.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port scl_in  input  1  I2C clock from bus master, asynchronous to sys_clk.
REQ-006 SHALL have port sda  inout  1  I2C data; open-drain: driven 0 or released to 1'bz, never driven 1.
REQ-007 SHALL have port tx_data  input  8  byte returned on read transfers.
REQ-008 SHALL have port tx_req  output  1  one-cycle pulse: tx_data sampled this cycle.
REQ-009 SHALL have port rx_data  output  8  last received write byte.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-011 SHALL have port addr_match  output  1  high from own-address ACK until STOP or repeated START.
REQ-012 SHALL have port busy  output  1  high from START detect until STOP detect.

Function
REQ-013 SHALL pass scl_in and sda through SYNC_STAGES flops, then one history flop, for edge detection.
REQ-014 SHALL detect START as synced sda 1->0 while synced scl high; STOP as sda 0->1 while scl high.
REQ-015 SHALL sample SDA bits on synced SCL rising edge, MSB first; SHALL change its SDA drive only on synced SCL falling edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-017 IDLE -> ADDR on START; ADDR collects 8 bits {addr[6:0], rw} with a 4-bit bit counter.
REQ-018 After 8th rising edge: if addr == SLAVE_ADDR -> ADDR_ACK; else -> WAIT_STOP, SDA never driven.
REQ-019 ADDR_ACK: pull SDA low from falling edge after 8th bit to falling edge after 9th bit; then rw=0 -> WR_DATA, rw=1 -> RD_DATA.
REQ-020 addr_match SHALL assert on the falling edge that starts the address ACK.
REQ-021 WR_DATA: shift 8 bits; on 8th rising edge load rx_data and pulse rx_valid one cycle, -> WR_ACK.
REQ-022 WR_ACK: drive ACK (low) for the 9th clock, then -> WR_DATA; unlimited consecutive bytes.
REQ-023 On entry to RD_DATA (falling edge ending ACK) SHALL capture tx_data, pulse tx_req, drive bit 7; later bits on subsequent falling edges; SDA released for 1 bits.
REQ-024 RD_ACK: release SDA, sample master bit on 9th rising edge; 0 (ACK) -> RD_DATA with new tx_data; 1 (NACK) -> WAIT_STOP.
REQ-025 WAIT_STOP: SDA released; leave only on STOP (-> IDLE) or START (-> ADDR).
REQ-026 STOP in any state SHALL force IDLE, release SDA, clear addr_match and busy next cycle.
REQ-027 Repeated START in any non-IDLE state SHALL force ADDR, clear bit counter and addr_match; a partial byte is discarded, no rx_valid.
REQ-028 START/STOP detection SHALL take priority over SCL edges in the same cycle.
REQ-029 rx_valid and tx_req SHALL never be high in the same cycle and SHALL never exceed one cycle.
REQ-030 Minimum supported ratio: SCL high and low phases each >= SYNC_STAGES+3 sys_clk cycles.

Reset
REQ-031 rst high SHALL immediately force: state IDLE, SDA released (1'bz), rx_data 8'h00, rx_valid 0, tx_req 0, addr_match 0, busy 0, bit counter 0, synchroniser flops 1.
REQ-032 rst asserted mid-transfer SHALL abandon the transfer; after release, block SHALL ignore the bus until next START.

Verification
REQ-033 Write: START, 0xA0 (addr 0x50, W), 0x3C, STOP -> two ACK lows on 9th clocks, one rx_valid with rx_data=0x3C, busy falls after STOP.
REQ-034 Address miss: START, 0xA2, 0x55, STOP -> SDA never driven low by DUT, no rx_valid, addr_match stays 0.
REQ-035 Read: START, 0xA1, tx_data=0x96, master NACK, STOP -> one tx_req, bus shows 1001_0110, then WAIT_STOP -> IDLE.
REQ-036 Multi-byte read: master ACKs first byte, tx_data 0x96 then 0x5A -> two tx_req pulses, bytes 0x96, 0x5A in order.
REQ-037 Repeated START after 4 data bits of write, then 0xA1 -> no rx_valid, read phase proceeds correctly.
REQ-038 rst pulse during 5th bit of write byte -> all outputs at reset values within 1 cycle; next full write of 0x11 received correctly.
